cpu_clock_gen: RTL and testbench
================================

// Module: cpu_clock_gen
// PURPOSE
//   Generates the CPU clock T and the synchronous-clear _SC that feed every
//   DFFModule flip-flop. All timing is derived from the fast fabric clock U.
//   After reset it runs a clear sequence: _SC is held low while T pulses, so every
//   flip-flop loads 0 through its D&_SC input. It then supports free-run or
//   single-step clocking under host (raspictl) control.
// PARAMETERS
//   CNTW       16  width of the half-period counters and the half_lo/half_hi inputs
//   CLRPULSES  4   number of T pulses generated with _SC low after reset (>=1)
// PORTS
//   U          in   1     fabric clock; all logic is on posedge U
//   RESET      in   1     asynchronous reset, active-high
//   run        in   1     1 = free-running T; 0 = stop at the next T-low boundary
//   step_req   in   1     rising edge requests exactly one T cycle while stopped
//   step_ack   out  1     one-U-cycle pulse when the requested step's T has fallen
//   half_lo    in   CNTW  T low phase lasts half_lo+1 U cycles
//   half_hi    in   CNTW  T high phase lasts half_hi+1 U cycles
//   stall      in   1     hold T low (active only with CPUCLK_STRETCH_EN)
//   T          out  1     CPU clock to the DFF T inputs; registered, glitch-free
//   _SC        out  1     synchronous clear to the DFF _SC inputs, active-low
//   busy       out  1     1 in any state other than IDLE
//   ncycles    out  32    count of T rising edges since reset; wraps 2^32-1 -> 0
// BEHAVIOUR
//   - RESET (async): state=CLR_LO, T=0, _SC=0, step_ack=0, ncycles=0, cnt=0,
//     step-edge detector cleared. Asserting RESET mid-phase truncates the phase;
//     this is the only case where a phase is truncated.
//   - Single down-counter cnt. It is loaded from half_lo or half_hi on entering a
//     phase and decrements every U. The phase ends on the U edge where cnt==0.
//     half_* are sampled only at phase entry; a change takes effect from the next phase.
//   - States:
//     CLR_LO -> CLR_HI : T=0, _SC=0.
//     CLR_HI -> CLR_LO : T=1, _SC=0. Repeats until CLRPULSES rising edges are done.
//     After the final CLR_HI, the sequence runs one more CLR_LO phase, then goes to
//     IDLE. _SC rises to 1 on entry to IDLE, so it is never released while T=1.
//     IDLE : T=0, _SC=1, busy=0.
//       run=1 -> LO.
//       Else, a step_req rising edge -> LO with the step flag set.
//     LO -> HI : T=0. On entry to HI, T rises and ncycles increments.
//     HI : at the end of the phase, -> LO if run=1 and the step flag is clear.
//       Otherwise -> IDLE, with T falling on that same edge.
//       If the step flag was set, step_ack=1 for exactly that U cycle and the flag
//       clears.
//   - run dropping mid-LO or mid-HI completes the current full T cycle first.
//     run and step never shorten a phase.
//   - step_req edges are ignored while run=1, while busy, or during the CLR
//     sequence; they are not queued. step_req is synchronised with 2 flops before
//     edge detection, which adds 2-3 U of latency from step_req to leaving IDLE.
//   - Minimum T period = 2 U (half_lo=half_hi=0). T, _SC and step_ack come straight
//     from registers, with no combinational path to outputs.
//   - ncycles also counts the CLR pulses (CLRPULSES after reset).
// CONFIGURATION
//   CPUCLK_STRETCH_EN defined:
//     In LO with cnt==0, stall=1 holds LO (cnt stays 0) until stall=0.
//     T rises on the first U edge with stall=0; this covers memory/IO wait states.
//     stall is ignored in all other states.
//   CPUCLK_STRETCH_EN undefined:
//     The stall port exists but is ignored, and no stretch logic is synthesised.
// TESTING
//   1. Reset, CLRPULSES=4, half_lo=half_hi=1, run=0:
//      4 T pulses, each 2 U high / 2 U low; _SC=0 throughout.
//      _SC rises only in IDLE; ncycles=4; busy=0.
//   2. After CLR, run=1, half_lo=3, half_hi=1: T period 6 U (4 low, 2 high).
//      Drop run mid-HI: the high phase completes, T falls, IDLE; no partial pulse.
//   3. run=0, pulse step_req once: exactly one T pulse, then one step_ack pulse
//      coincident with the T fall. ncycles +1.
//      A second step_req while busy is ignored.
//   4. half_lo changed 0->5 mid-LO: the current LO keeps the old length; the next LO
//      is 6 U. half_*=0 yields a T period of 2 U.
//   5. Assert RESET while T=1: T=0 and _SC=0 immediately (async), ncycles=0, and the
//      clear sequence restarts after release.
//   6. CPUCLK_STRETCH_EN, run=1, stall=1 for 10 U: T stays low, then rises 1 U after
//      stall drops. Without the macro, the period is unchanged.

Source files
------------

// File: rtl/cpu_clock_gen.sv
// cpu_clock_gen: CPU clock T and active-low sync clear _SC from fabric clock U (optional stall stretch: CPUCLK_STRETCH_EN)
module cpu_clock_gen #(
  parameter int CNTW      = 16,
  parameter int CLRPULSES = 4
) (
  input  logic            U,
  input  logic            RESET,
  input  logic            run,
  input  logic            step_req,
  output logic            step_ack,
  input  logic [CNTW-1:0] half_lo,
  input  logic [CNTW-1:0] half_hi,
  input  logic            stall,
  output logic            T,
  output logic            _SC,
  output logic            busy,
  output logic [31:0]     ncycles
);
  localparam int PW = $clog2(CLRPULSES + 1);
  typedef enum logic [2:0] {CLR_LO, CLR_HI, IDLE, LO, HI} state_t;
  state_t state, state_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [PW-1:0] clr, clr_n;
  logic [31:0] nc_n;
  logic [2:0] sync;
  logic t_n, sc_n, ack_n, flag, flag_n, done, step_edge, hold;
  assign done = cnt == '0;
  assign step_edge = sync[1] & ~sync[2];
  assign busy = state != IDLE;
`ifdef CPUCLK_STRETCH_EN
  assign hold = stall;
`else
  assign hold = stall & 1'b0;
`endif
  // two-flop synchroniser plus one delay stage for step_req edge detection
  always_ff @(posedge U or posedge RESET)
    if (RESET) sync <= '0;
    else sync <= {sync[1:0], step_req};
  // state and output registers; T, _SC and step_ack leave straight from flops
  always_ff @(posedge U or posedge RESET)
    if (RESET) begin
      state    <= CLR_LO;
      cnt      <= '0;
      clr      <= '0;
      T        <= 1'b0;
      _SC      <= 1'b0;
      step_ack <= 1'b0;
      flag     <= 1'b0;
      ncycles  <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      clr      <= clr_n;
      T        <= t_n;
      _SC      <= sc_n;
      step_ack <= ack_n;
      flag     <= flag_n;
      ncycles  <= nc_n;
    end
  // next-state: phases end when cnt hits zero, half_* sampled only on phase entry
  always_comb begin
    state_n = state;
    cnt_n   = cnt - CNTW'(1);
    clr_n   = clr;
    t_n     = T;
    sc_n    = _SC;
    ack_n   = 1'b0;
    flag_n  = flag;
    nc_n    = ncycles;
    unique case (state)
      CLR_LO:
        if (done && clr == PW'(CLRPULSES)) begin
          state_n = IDLE;
          sc_n    = 1'b1;
          cnt_n   = '0;
        end else if (done) begin
          state_n = CLR_HI;
          t_n     = 1'b1;
          cnt_n   = half_hi;
          clr_n   = clr + PW'(1);
          nc_n    = ncycles + 32'd1;
        end
      CLR_HI:
        if (done) begin
          state_n = CLR_LO;
          t_n     = 1'b0;
          cnt_n   = half_lo;
        end
      IDLE: begin
        cnt_n = cnt;
        if (run || step_edge) begin
          state_n = LO;
          cnt_n   = half_lo;
          flag_n  = ~run;
        end
      end
      LO:
        if (done && hold) cnt_n = '0;
        else if (done) begin
          state_n = HI;
          t_n     = 1'b1;
          cnt_n   = half_hi;
          nc_n    = ncycles + 32'd1;
        end
      HI:
        if (done) begin
          t_n     = 1'b0;
          cnt_n   = half_lo;
          state_n = (run && !flag) ? LO : IDLE;
          ack_n   = flag;
          flag_n  = 1'b0;
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cpu_clock_gen.sv
// tb_cpu_clock_gen: directed checks of clear sequence, run, step, half-period change, stall and reset
module tb_cpu_clock_gen;
  logic U = 1'b0, RESET = 1'b1, run = 1'b0, step_req = 1'b0, stall = 1'b0;
  logic [15:0] half_lo = 16'd1, half_hi = 16'd1;
  logic step_ack, T, sc, busy;
  logic [31:0] ncycles;
  int checks = 0, errors = 0;

  cpu_clock_gen #(.CNTW(16), .CLRPULSES(4)) dut (
    .U(U), .RESET(RESET), .run(run), .step_req(step_req), .step_ack(step_ack),
    .half_lo(half_lo), .half_hi(half_hi), .stall(stall), .T(T), ._SC(sc),
    .busy(busy), .ncycles(ncycles)
  );

  always #5 U = ~U;

  task automatic test_reset;
    RESET = 1'b1;
    @(negedge U);
    @(negedge U);
    checks++;
    if (T !== 1'b0 || sc !== 1'b0 || ncycles !== 32'd0 || busy !== 1'b1 || step_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset: T=%b _SC=%b nc=%0d busy=%b ack=%b, want 0 0 0 1 0", T, sc, ncycles, busy, step_ack);
    end
  endtask

  // releases RESET and checks the four clear pulses, then IDLE with _SC high
  task automatic test_clear;
    half_lo = 16'd1;
    half_hi = 16'd1;
    run = 1'b0;
    RESET = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge U);
      checks++;
      if (T !== (k % 4 == 1 || k % 4 == 2) && k <= 14) begin
        errors++;
        $display("FAIL clear_T k=%0d: T=%b", k, T);
      end
      checks++;
      if (sc !== (k >= 17)) begin
        errors++;
        $display("FAIL clear_SC k=%0d: _SC=%b want %b", k, sc, k >= 17);
      end
    end
    checks++;
    if (ncycles !== 32'd4 || busy !== 1'b0 || T !== 1'b0) begin
      errors++;
      $display("FAIL clear_end: nc=%0d busy=%b T=%b, want 4 0 0", ncycles, busy, T);
    end
  endtask

  task automatic test_run;
    half_lo = 16'd3;
    half_hi = 16'd1;
    run = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge U);
      checks++;
      if (T !== (k == 5 || k == 6 || k == 11 || k == 12)) begin
        errors++;
        $display("FAIL run_T k=%0d: T=%b", k, T);
      end
      checks++;
      if (busy !== (k <= 12)) begin
        errors++;
        $display("FAIL run_busy k=%0d: busy=%b want %b", k, busy, k <= 12);
      end
      if (k == 11) run = 1'b0;
    end
    checks++;
    if (ncycles !== 32'd6) begin
      errors++;
      $display("FAIL run_nc: got %0d want 6", ncycles);
    end
  endtask

  task automatic test_step;
    half_lo = 16'd1;
    half_hi = 16'd1;
    step_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge U);
      checks++;
      if (T !== (k == 5 || k == 6) || busy !== (k >= 3 && k <= 6) || step_ack !== (k == 7)) begin
        errors++;
        $display("FAIL step k=%0d: T=%b busy=%b ack=%b", k, T, busy, step_ack);
      end
      if (k == 3) step_req = 1'b0;
      if (k == 4) step_req = 1'b1;
      if (k == 10) step_req = 1'b0;
    end
    checks++;
    if (ncycles !== 32'd7) begin
      errors++;
      $display("FAIL step_nc: got %0d want 7", ncycles);
    end
  endtask

  task automatic test_half_change;
    half_lo = 16'd0;
    half_hi = 16'd0;
    run = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge U);
      checks++;
      if (T !== ((k <= 6 && k % 2 == 0) || k == 13)) begin
        errors++;
        $display("FAIL half_T k=%0d: T=%b", k, T);
      end
      if (k == 5) half_lo = 16'd5;
      if (k == 13) run = 1'b0;
    end
    checks++;
    if (busy !== 1'b0 || ncycles !== 32'd11) begin
      errors++;
      $display("FAIL half_end: busy=%b nc=%0d, want 0 11", busy, ncycles);
    end
  endtask

  task automatic test_stall;
    logic exp_t;
    logic [31:0] exp_nc;
    half_lo = 16'd1;
    half_hi = 16'd1;
    stall = 1'b1;
    run = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge U);
`ifdef CPUCLK_STRETCH_EN
      exp_t = k == 11 || k == 12;
`else
      exp_t = k == 3 || k == 4 || k == 7 || k == 8 || k == 11 || k == 12;
`endif
      checks++;
      if (T !== exp_t) begin
        errors++;
        $display("FAIL stall_T k=%0d: T=%b want %b", k, T, exp_t);
      end
      if (k == 10) stall = 1'b0;
      if (k == 11) run = 1'b0;
    end
`ifdef CPUCLK_STRETCH_EN
    exp_nc = 32'd12;
`else
    exp_nc = 32'd14;
`endif
    checks++;
    if (ncycles !== exp_nc || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: nc=%0d busy=%b, want %0d 0", ncycles, busy, exp_nc);
    end
  endtask

  task automatic test_reset_mid;
    half_lo = 16'd1;
    half_hi = 16'd1;
    run = 1'b1;
    for (int k = 1; k <= 3; k++) @(negedge U);
    checks++;
    if (T !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: T=%b want 1", T);
    end
    RESET = 1'b1;
    #1;
    checks++;
    if (T !== 1'b0 || sc !== 1'b0 || ncycles !== 32'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: T=%b _SC=%b nc=%0d busy=%b, want 0 0 0 1", T, sc, ncycles, busy);
    end
    run = 1'b0;
    @(negedge U);
    @(negedge U);
    test_clear();
  endtask

  initial begin
    test_reset();
    test_clear();
    test_run();
    test_step();
    test_half_change();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
